// File: rtl/counter_8bit_if.sv
// Control/status bundle for counter_8bit: master drives the controls, slave is the counter.
interface counter_8bit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, up_dn, load, load_val,
    input  count, zero, tc, wrapped
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output count, zero, tc, wrapped
  );
endinterface

// File: rtl/counter_8bit.sv
// Up/down counter with clamped parallel load, zero/terminal-count/sticky-wrap status.
// Define COUNTER_8BIT_SATURATE_EN to pin at the limits instead of wrapping.
module counter_8bit #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           reset,
  counter_8bit_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_count_next;
  logic             w_tc_next;
  logic             w_wrapped_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_limit_hit;

  assign w_load_clamped = (bus.load_val > MAX_VALUE) ? MAX_VALUE : bus.load_val;
  assign w_limit_hit    = bus.en && !bus.load &&
                          (bus.up_dn ? (r_count == MAX_VALUE) : (r_count == '0));

`ifdef COUNTER_8BIT_SATURATE_EN
  // Remembers that the count is already pinned, so repeated pushes at a limit pulse tc only once.
  logic r_pinned;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pinned <= 1'b0;
    end else if (bus.load) begin
      r_pinned <= 1'b0;
    end else if (bus.en) begin
      r_pinned <= w_limit_hit;
    end
  end
`endif

  always_comb begin
    w_count_next   = r_count;
    w_tc_next      = 1'b0;
    w_wrapped_next = r_wrapped;
    if (bus.load) begin
      w_count_next   = w_load_clamped;
      w_wrapped_next = 1'b0;
    end else if (bus.en) begin
      if (w_limit_hit) begin
`ifdef COUNTER_8BIT_SATURATE_EN
        w_count_next = r_count;
        w_tc_next    = !r_pinned;
`else
        w_count_next = bus.up_dn ? '0 : MAX_VALUE;
        w_tc_next    = 1'b1;
`endif
        w_wrapped_next = 1'b1;
      end else begin
        w_count_next = bus.up_dn ? (r_count + ONE) : (r_count - ONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count   <= RESET_VALUE;
      r_tc      <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_tc      <= w_tc_next;
      r_wrapped <= w_wrapped_next;
    end
  end

  assign bus.count   = r_count;
  assign bus.zero    = (r_count == '0);
  assign bus.tc      = r_tc;
  assign bus.wrapped = r_wrapped;

endmodule

// File: tb/tb_counter_8bit.sv
// Bench for counter_8bit: a full-range instance and a MAX_VALUE=99 instance checked against a reference model.
module tb_counter_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_en, s_up_dn, s_load;
  logic [7:0] s_load_val;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned mx[2] = '{255, 99};
  int unsigned rv[2] = '{0, 7};
  int unsigned m_cnt[2];
  bit          m_tc[2];
  bit          m_wr[2];
  bit          m_pin[2];

  counter_8bit_if #(.WIDTH(8)) if_a ();
  counter_8bit_if #(.WIDTH(8)) if_b ();

  assign if_a.en = s_en;  assign if_a.up_dn = s_up_dn;
  assign if_a.load = s_load;  assign if_a.load_val = s_load_val;
  assign if_b.en = s_en;  assign if_b.up_dn = s_up_dn;
  assign if_b.load = s_load;  assign if_b.load_val = s_load_val;

  counter_8bit #(.WIDTH(8)) dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_a)
  );

  counter_8bit #(.WIDTH(8), .MAX_VALUE(8'd99), .RESET_VALUE(8'd7)) dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: applies one clock edge of the documented rules to instance k.
  function automatic void model_edge(int k);
    bit limit;
    if (!rst_n) begin
      m_cnt[k] = rv[k]; m_tc[k] = 0; m_wr[k] = 0; m_pin[k] = 0;
    end else if (s_load) begin
      m_cnt[k] = (int'(s_load_val) > int'(mx[k])) ? mx[k] : int'(s_load_val);
      m_tc[k] = 0; m_wr[k] = 0; m_pin[k] = 0;
    end else if (s_en) begin
      limit = s_up_dn ? (m_cnt[k] == mx[k]) : (m_cnt[k] == 0);
`ifdef COUNTER_8BIT_SATURATE_EN
      if (limit) begin
        m_tc[k] = !m_pin[k]; m_wr[k] = 1; m_pin[k] = 1;
      end else begin
        m_cnt[k] = s_up_dn ? m_cnt[k] + 1 : m_cnt[k] - 1;
        m_tc[k] = 0; m_pin[k] = 0;
      end
`else
      m_cnt[k] = s_up_dn ? (m_cnt[k] + 1) % (mx[k] + 1) : (m_cnt[k] + mx[k]) % (mx[k] + 1);
      m_tc[k] = limit;
      if (limit) m_wr[k] = 1;
`endif
    end else begin
      m_tc[k] = 0;
    end
  endfunction

  task automatic drive(input bit r, input bit ld, input logic [7:0] lv, input bit e, input bit ud);
    rst_n = r; s_load = ld; s_load_val = lv; s_en = e; s_up_dn = ud;
  endtask

  task automatic step(input string tag);
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check({tag, " a.count"},   longint'(if_a.count),   longint'(m_cnt[0]));
    check({tag, " a.zero"},    longint'(if_a.zero),    longint'(m_cnt[0] == 0));
    check({tag, " a.tc"},      longint'(if_a.tc),      longint'(m_tc[0]));
    check({tag, " a.wrapped"}, longint'(if_a.wrapped), longint'(m_wr[0]));
    check({tag, " b.count"},   longint'(if_b.count),   longint'(m_cnt[1]));
    check({tag, " b.zero"},    longint'(if_b.zero),    longint'(m_cnt[1] == 0));
    check({tag, " b.tc"},      longint'(if_b.tc),      longint'(m_tc[1]));
    check({tag, " b.wrapped"}, longint'(if_b.wrapped), longint'(m_wr[1]));
    $display("%-8s rst=%0b ld=%0b lv=%0d en=%0b up=%0b | a=%0d tc=%0b wr=%0b | b=%0d tc=%0b wr=%0b",
             tag, rst_n, s_load, s_load_val, s_en, s_up_dn,
             if_a.count, if_a.tc, if_a.wrapped, if_b.count, if_b.tc, if_b.wrapped);
  endtask

  initial begin
    drive(0, 0, 8'd0, 1, 1);
    step("reset");
    check("reset a.count literal", longint'(if_a.count), 0);
    check("reset b.count literal", longint'(if_b.count), 7);

    drive(1, 0, 8'd0, 1, 1);
    for (int i = 0; i < 30; i++) step("run");
    check("run30 a.count literal", longint'(if_a.count), 30);

    drive(1, 1, 8'd254, 0, 1);
    step("ld254");
    drive(1, 0, 8'd0, 1, 1);
    for (int i = 0; i < 3; i++) step("wrapup");
`ifndef COUNTER_8BIT_SATURATE_EN
    check("wrapup a.count literal", longint'(if_a.count), 1);
`else
    check("satup a.count literal", longint'(if_a.count), 255);
`endif

    drive(1, 1, 8'd1, 0, 0);
    step("ld1");
    drive(1, 0, 8'd0, 1, 0);
    for (int i = 0; i < 3; i++) step("wrapdn");

    drive(1, 1, 8'd30, 0, 1);
    step("ld30");
    drive(0, 1, 8'd77, 1, 1);
    for (int i = 0; i < 2; i++) step("midrst");
    check("midrst a.wrapped literal", longint'(if_a.wrapped), 0);
    drive(1, 0, 8'd0, 1, 1);
    for (int i = 0; i < 3; i++) step("resume");

    drive(1, 1, 8'd200, 1, 1);
    step("clamp");
    check("clamp b.count literal", longint'(if_b.count), 99);
    drive(1, 0, 8'd0, 1, 1);
    step("clampup");

    drive(1, 1, 8'd17, 0, 1);
    step("ld17");
    drive(1, 0, 8'd0, 0, 1);
    for (int i = 0; i < 5; i++) step("hold");
    check("hold a.count literal", longint'(if_a.count), 17);

    for (int i = 0; i < 1500; i++) begin
      logic [7:0] lv;
      lv = 8'($urandom);
      if ($urandom_range(0, 3) == 0) lv = 8'($urandom_range(0, 1) ? $urandom_range(95, 104) : $urandom_range(250, 255));
      drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) == 0), lv,
            ($urandom_range(0, 3) != 0), (($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
